// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared FSM state type, 16-lamp default phase table and bound-legality check
package bound_flasher_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Phases 0..5 = 16, 5, 11, 0, 6, 0 (phase 0 in the LSBs, 5 bits each)
    localparam logic [29:0] DEF_PHASE_BOUND = {5'd0, 5'd6, 5'd0, 5'd11, 5'd5, 5'd16};
    // Lit counts 0 and 5 are kickback points
    localparam logic [16:0] DEF_KICK_MASK = 17'h00021;

    // Fill bounds must rise above the previous bound, drain bounds must fall below it,
    // and none may exceed the lamp count; the walk starts from an empty bar.
    function automatic bit bounds_legal(input logic [1023:0] b, input int n_lamps,
                                        input int n_phases, input int cnt_w);
        logic [1023:0] s;
        int prev;
        int cur;
        bit ok;
        prev = 0;
        ok = 1'b1;
        for (int i = 0; i < n_phases; i++) begin
            s = b >> (i * cnt_w);
            cur = int'(s[31:0]) & ((1 << cnt_w) - 1);
            if (cur > n_lamps || ((i % 2 == 0) ? (cur <= prev) : (cur >= prev)))
                ok = 1'b0;
            prev = cur;
        end
        return ok;
    endfunction

endpackage

// File: rtl/flasher_therm.sv
// flasher_therm: combinational lit-count to thermometer-bar decoder
module flasher_therm #(
    parameter int N_LAMPS = 16,
    localparam int CNT_W = $clog2(N_LAMPS + 1)
) (
    input  logic [CNT_W-1:0]   cnt,
    output logic [N_LAMPS-1:0] bar
);

    for (genvar i = 0; i < N_LAMPS; i++) begin : g_bar
        assign bar[i] = cnt > CNT_W'(i);
    end

endmodule

// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen: N-lamp fill/drain sequencer with flick start and drain-phase kickback.
// Define BOUND_FLASHER_LOOP_EN to repeat the phase list forever instead of returning to IDLE.
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int N_LAMPS = 16,
    parameter int N_PHASES = 6,
    parameter int CNT_W = $clog2(N_LAMPS + 1),
    parameter logic [N_PHASES*CNT_W-1:0] PHASE_BOUND = DEF_PHASE_BOUND,
    parameter logic [N_LAMPS:0] KICK_MASK = DEF_KICK_MASK,
    localparam int PW = $clog2(N_PHASES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flick,
    output logic [N_LAMPS-1:0] lamps,
    output logic               busy,
    output logic [PW-1:0]      phase
);

    localparam logic [PW-1:0] LAST = PW'(N_PHASES - 1);

    if (N_LAMPS < 2 || N_PHASES < 2 || N_PHASES % 2 != 0) begin : g_bad_cfg
        $error("bound_flasher_gen: need N_LAMPS >= 2 and an even N_PHASES >= 2");
    end
    if (!bounds_legal(1024'(PHASE_BOUND), N_LAMPS, N_PHASES, CNT_W)) begin : g_bad_bound
        $error("bound_flasher_gen: PHASE_BOUND is not a legal fill/drain sequence");
    end

    state_t             state, state_n;
    logic [CNT_W-1:0]   l, l_n, l_step, cur_bound;
    logic [PW-1:0]      p, p_n;
    logic [N_LAMPS-1:0] bar_n;
    logic               kick, hit;

    assign cur_bound = CNT_W'(PHASE_BOUND >> (int'(p) * CNT_W));
    assign l_step    = p[0] ? l - CNT_W'(1) : l + CNT_W'(1);
    assign kick      = p[0] && p != LAST && flick && KICK_MASK[l_step];
    assign hit       = l_step == cur_bound;

    flasher_therm #(.N_LAMPS(N_LAMPS)) u_therm (
        .cnt(l_n),
        .bar(bar_n)
    );

    // Step the lit count each RUN edge; kickback wins over a bound hit on the same count
    always_comb begin
        state_n = state;
        l_n = l;
        p_n = p;
        if (state == RUN) begin
            l_n = l_step;
            if (kick) begin
                p_n = p - PW'(1);
            end else if (hit) begin
                p_n = (p == LAST) ? '0 : p + PW'(1);
`ifndef BOUND_FLASHER_LOOP_EN
                state_n = (p == LAST) ? IDLE : RUN;
`endif
            end
        end else begin
            state_n = flick ? RUN : IDLE;
        end
    end

    // State and registered outputs; the bar is decoded from the next count so it tracks L exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            l     <= '0;
            p     <= '0;
            lamps <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            l     <= l_n;
            p     <= p_n;
            lamps <= bar_n;
            busy  <= state_n == RUN;
        end
    end

    assign phase = p;

endmodule

// File: doc/bound_flasher_gen.md
# bound_flasher_gen

Parametrised lamp-sequencer that drives an N-lamp thermometer bar through a programmable list of alternating fill/drain phases. A `flick` input starts a run. Held at a kickback point during a drain phase, `flick` sends the sequence back to the preceding fill phase. It is the generalised successor to the fixed 16-lamp, 6-phase flasher and sits directly behind the board's lamp drivers.

## Interface
- `N_LAMPS`, 16: number of lamps; ≥2.
- `N_PHASES`, 6: number of phases; even, ≥2. Even index = fill (ON), odd index = drain (OFF).
- `CNT_W`, `$clog2(N_LAMPS+1)`: lit-count width. Derived; not overridden.
- `PHASE_BOUND`, packed `N_PHASES*CNT_W` bits, phase 0 in LSBs:
  - default phases 0..5 = 16, 5, 11, 0, 6, 0.
  - Each ON bound must be > the previous bound; each OFF bound must be < it; all bounds ≤ N_LAMPS. Violation is an elaboration `$error`.
- `KICK_MASK`, `N_LAMPS+1` bits: bit i set = lit count i is a kickback point. Default bits 0 and 5 set.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flick` in 1: start/kickback request. Synchronous to `clk`; the upstream synchroniser owns metastability.
- `lamps` out N_LAMPS: thermometer bar; `lamps[i]=1` iff i < L.
- `busy` out 1: sequence running.
- `phase` out `$clog2(N_PHASES)`: current phase index, for debug.

## Operation
- State is FSM {IDLE, RUN}, lit count L (CNT_W bits), phase index p.
- IDLE: L=0, p=0. `flick`=1 sampled at an edge → RUN; L and p unchanged on that edge.
- RUN, each edge:
  - Compute L' = L+1 if p is even, else L−1. L ← L'.
  - Kickback: p odd, p ≠ N_PHASES−1, `flick`=1, and `KICK_MASK[L']`=1 → p ← p−1. Kickback has priority over a bound hit at the same L'.
  - Otherwise, if L' == bound[p]:
    - p < N_PHASES−1 → p ← p+1.
    - p == N_PHASES−1 → FSM ← IDLE, p ← 0.
  - `flick` is ignored during ON phases and during the final phase.
- Arithmetic: L never leaves [0, N_LAMPS] because bounds are checked at elaboration. No wrap logic is required.
- Kickback may repeat indefinitely. Each occurrence re-enters the fill phase from the current L.

## Timing
- Reset values: `lamps`=0, `busy`=0, `phase`=0, FSM=IDLE, L=0. Reset takes effect immediately on `rst_n` fall, including mid-run. No output glitch after release.
- All outputs are registered; `lamps` is decoded from the L register.
- Start latency: `flick` edge → `busy`=1 on that edge; `lamps[0]`=1 one edge later.
- With no kickback, defaults give 56 stepping edges. `busy` drops on the edge where L returns to 0 in phase 5.
- `flick` high on the same edge that enters IDLE is ignored. `flick` high on the next edge restarts the run.

## Configuration
- `BOUND_FLASHER_LOOP_EN`:
  - Defined: completing the final phase sets p ← 0 and stays in RUN, so the sequence repeats until reset and `busy` stays 1.
  - Undefined: the FSM returns to IDLE and waits for `flick`.

## Structure
- `bound_flasher_pkg` holds:
  - the FSM state enum;
  - default `PHASE_BOUND` and `KICK_MASK` constants for N_LAMPS=16;
  - the bound-legality check function used by the elaboration assertion.
- Sub-module `flasher_therm`: purely combinational count-to-thermometer decoder, parameter `N_LAMPS`, followed by the output register in the parent.

## Test plan
- Reset mid-run: drop `rst_n` at L=9 in phase 0 → same instant `lamps`=0, `busy`=0, `phase`=0; no activity until the next `flick`.
- Single 1-cycle `flick`, defaults → L sequence is 1..16, 15..5, 6..11, 10..0, 1..6, 5..0 over 56 edges, then `busy`=0 and `lamps`=0.
- Phase-1 kickback: `flick` high when L'=5 in phase 1 → `phase`=0, L climbs 6..16, then drains to 5 again.
- Phase-3 mid-drain kickback: `flick` high at L'=5 while draining from 11 → `phase`=2, L goes 6..11, then phase 3 resumes.
- No kickback in the final phase or ON phases: `flick` held high throughout phase 5 → run ends at L=0. `flick` during phase 0 has no effect.
- N_LAMPS=8, N_PHASES=2, bounds {8,0}:
  - without the macro → 8 up, 8 down, then IDLE;
  - with `BOUND_FLASHER_LOOP_EN` → the cycle repeats and `busy` stays 1.
